axi_ar_arbiter_ctrl: RTL and testbench

//  Sequences and shares the memory slave's single AXI read-address (AR) channel among NUM_REQ read requesters.

---
 rtl/axi_ar_arbiter_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_axi_ar_arbiter_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ar_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_ar_arbiter_ctrl
// Description : Round-robin arbiter for one AXI read-address channel, gated by
//               memory calibration and capped on bursts in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ar_arbiter_ctrl #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 8,
    parameter int ID_W            = 3,
    parameter int MAX_OUTSTANDING = 8,
    parameter int SETTLE_CYCLES   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init_calib_complete,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [ADDR_W-1:0]         araddr,
    output logic [LEN_W-1:0]          arlen,
    output logic [ID_W-1:0]           arid,
    input  logic                      rvalid,
    input  logic                      rready,
    input  logic                      rlast,
    output logic                      ctrl_ready,
    output logic [7:0]                outstanding,
    output logic                      err_underflow
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       c_max_out     = 8'(MAX_OUTSTANDING);
    localparam logic [ID_W-1:0]  c_last_init   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_WAIT_CAL = 2'd0,
        S_SETTLE   = 2'd1,
        S_IDLE     = 2'd2,
        S_ISSUE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_cal_meta;
    logic               r_cal_s;
    logic [CNT_W-1:0]   r_settle_cnt;
    logic [ID_W-1:0]    r_last_grant;
    logic               r_arvalid;
    logic [ADDR_W-1:0]  r_araddr;
    logic [LEN_W-1:0]   r_arlen;
    logic [ID_W-1:0]    r_arid;
    logic [7:0]         r_outstanding;
    logic               r_err_underflow;

    logic               w_gnt_found;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic [ADDR_W-1:0]  w_gnt_addr;
    logic [LEN_W-1:0]   w_gnt_len;
    logic               w_grant;
    logic               w_ar_hs;
    logic               w_r_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cal_meta <= 1'b0;
            r_cal_s    <= 1'b0;
        end else begin
            r_cal_meta <= init_calib_complete;
            r_cal_s    <= r_cal_meta;
        end
    end

    // Two passes give the rotating priority: indices above the last grant
    // first, then wrap around to the low indices.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_gnt_addr  = '0;
        w_gnt_len   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_gnt_found && req_valid[i] && (i > int'(r_last_grant))) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = ID_W'(i);
                w_gnt_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_gnt_len   = req_len[i*LEN_W +: LEN_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_gnt_found && req_valid[i] && (i <= int'(r_last_grant))) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = ID_W'(i);
                w_gnt_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_gnt_len   = req_len[i*LEN_W +: LEN_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gnt_onehot[i] = w_gnt_found && (w_gnt_idx == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_WAIT_CAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_WAIT_CAL: begin
                if (r_cal_s) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!r_cal_s) begin
                    w_state_nxt = S_WAIT_CAL;
                end else if (r_settle_cnt == c_settle_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!r_cal_s) begin
                    w_state_nxt = S_WAIT_CAL;
                end else if (w_gnt_found && (r_outstanding < c_max_out)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A presented beat is never withdrawn, even if calibration drops.
                if (arready) begin
                    w_state_nxt = r_cal_s ? S_IDLE : S_WAIT_CAL;
                end
            end
            default: w_state_nxt = S_WAIT_CAL;
        endcase
    end

    assign w_ar_hs  = r_arvalid & arready;
    assign w_r_last = rvalid & rready & rlast;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_settle_cnt <= '0;
            r_last_grant <= c_last_init;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arid       <= '0;
        end else begin
            if (r_state == S_WAIT_CAL) begin
                r_settle_cnt <= '0;
            end else if (r_state == S_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + CNT_W'(1);
            end
            if (w_grant) begin
                r_arvalid    <= 1'b1;
                r_araddr     <= w_gnt_addr;
                r_arlen      <= w_gnt_len;
                r_arid       <= w_gnt_idx;
                r_last_grant <= w_gnt_idx;
            end else if (w_ar_hs) begin
                r_arvalid <= 1'b0;
            end
        end
    end

    // Simultaneous issue and completion cancel; a completion with nothing in
    // flight is flagged rather than wrapping the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_outstanding   <= 8'd0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_ar_hs && !w_r_last) begin
                r_outstanding <= r_outstanding + 8'd1;
            end else if (w_r_last && !w_ar_hs) begin
                if (r_outstanding == 8'd0) begin
                    r_err_underflow <= 1'b1;
                end else begin
                    r_outstanding <= r_outstanding - 8'd1;
                end
            end
        end
    end

    assign req_ready     = w_grant ? w_gnt_onehot : '0;
    assign arvalid       = r_arvalid;
    assign araddr        = r_araddr;
    assign arlen         = r_arlen;
    assign arid          = r_arid;
    assign ctrl_ready    = (r_state == S_IDLE) || (r_state == S_ISSUE);
    assign outstanding   = r_outstanding;
    assign err_underflow = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_axi_ar_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_ar_arbiter_ctrl
// Description : Bench for axi_ar_arbiter_ctrl against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_ar_arbiter_ctrl;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 8;
    localparam int ID_W    = 3;
    localparam int MAX_OUT = 8;
    localparam int SETTLE  = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      init_calib_complete;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_W-1:0]         araddr;
    logic [LEN_W-1:0]          arlen;
    logic [ID_W-1:0]           arid;
    logic                      rvalid;
    logic                      rready;
    logic                      rlast;
    logic                      ctrl_ready;
    logic [7:0]                outstanding;
    logic                      err_underflow;

    always #5 clk = ~clk;

    axi_ar_arbiter_ctrl #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W),
        .MAX_OUTSTANDING(MAX_OUT), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready), .arvalid(arvalid), .arready(arready),
        .araddr(araddr), .arlen(arlen), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .ctrl_ready(ctrl_ready), .outstanding(outstanding),
        .err_underflow(err_underflow)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: an AR beat either pending or not, a burst count, a sticky
    // error, the last winner and whether grants are currently permitted.
    bit              m_busy;
    logic [ADDR_W-1:0] m_addr;
    logic [LEN_W-1:0]  m_len;
    int              m_id;
    int              m_out;
    bit              m_err;
    int              m_last;
    bit              m_cal_ok;
    int              ar_ids[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx = (m_last + k) % NUM_REQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_addr = '0; m_len = '0; m_id = 0;
        m_out = 0; m_err = 0; m_last = NUM_REQ - 1; m_cal_ok = 0;
    endtask

    // Called mid-cycle with inputs stable: checks outputs, then advances the
    // model to what the coming edge should produce.
    task automatic model_cycle();
        int g;
        bit hs, dec;
        logic [63:0] exp_rr;
        g = (m_cal_ok && !m_busy && m_out < MAX_OUT) ? rr_pick() : -1;
        exp_rr = '0;
        if (g >= 0) exp_rr[g] = 1'b1;
        chk("req_ready", 64'(req_ready), exp_rr);
        chk("arvalid", 64'(arvalid), 64'(m_busy));
        if (m_busy) begin
            chk("araddr", 64'(araddr), 64'(m_addr));
            chk("arlen", 64'(arlen), 64'(m_len));
            chk("arid", 64'(arid), 64'(m_id));
        end
        chk("outstanding", 64'(outstanding), 64'(m_out));
        chk("err_underflow", 64'(err_underflow), 64'(m_err));
        hs  = m_busy && arready;
        dec = rvalid && rready && rlast;
        if (hs) begin
            ar_ids.push_back(m_id);
            m_busy = 0;
        end
        if (hs && !dec) m_out++;
        else if (dec && !hs) begin
            if (m_out == 0) m_err = 1;
            else m_out--;
        end
        if (g >= 0) begin
            m_busy = 1;
            m_addr = req_addr[g*ADDR_W +: ADDR_W];
            m_len  = req_len[g*LEN_W +: LEN_W];
            m_id   = g;
            m_last = g;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = $urandom;
            req_len[i*LEN_W +: LEN_W]    = LEN_W'($urandom_range(0, 255));
        end
    endtask

    task automatic r_idle();
        rvalid = 0; rready = 0; rlast = 0;
    endtask

    task automatic r_beat();
        rvalid = 1; rready = 1; rlast = 1;
    endtask

    task automatic drain_to(input int level);
        req_valid = '0;
        arready   = 1;
        for (int i = 0; i < 300 && (m_out > level || m_busy); i++) begin
            if (m_out > level) r_beat(); else r_idle();
            step();
        end
        r_idle();
        chk("drain_done", 64'(m_out <= level && !m_busy), 64'd1);
    endtask

    initial begin
        int n;
        int keep;
        model_reset();
        reset = 0; init_calib_complete = 0; req_valid = '1; arready = 0;
        r_idle();
        rand_payload();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_ctrl_ready", 64'(ctrl_ready), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(err_underflow), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_arlen", 64'(arlen), 64'd0);
        chk("rst_arid", 64'(arid), 64'd0);
        reset = 1;

        // Uncalibrated: nothing may be granted.
        repeat (50) step();

        // Calibration driven just after edge P0; sampled at P1, synced at P2,
        // SETTLE from P3 for 16 edges, IDLE after P19: the 20th negedge.
        arready = 1;
        init_calib_complete = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 100);
        chk("cal_latency", 64'(n), 64'd20);
        chk("ctrl_ready_cal", 64'(ctrl_ready), 64'd1);
        m_cal_ok = 1;
        model_cycle();
        @(posedge clk);
        #1;

        // All requesters busy, no R traffic: 8 ARs in rotation then stall.
        repeat (40) step();
        chk("rr_count", 64'(ar_ids.size()), 64'd8);
        for (int i = 0; i < ar_ids.size() && i < 8; i++) chk("rr_id", 64'(ar_ids[i]), 64'(i % 4));
        chk("cap_outstanding", 64'(outstanding), 64'd8);
        r_beat();
        step();
        r_idle();
        repeat (10) step();
        chk("resume_count", 64'(ar_ids.size()), 64'd9);
        if (ar_ids.size() == 9) chk("resume_id", 64'(ar_ids[8]), 64'd0);

        // Stalled arready with the requester payloads changing underneath.
        drain_to(5);
        arready = 0;
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            rand_payload();
            step();
        end
        chk("stall_arvalid", 64'(arvalid), 64'd1);
        arready = 1;
        step();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            req_valid = NUM_REQ'($urandom_range(0, 15));
            rand_payload();
            arready = ($urandom_range(0, 99) < 60);
            rvalid  = $urandom_range(0, 1);
            rready  = $urandom_range(0, 1);
            rlast   = $urandom_range(0, 1);
            if (m_out == 0) rlast = 0;
            step();
        end
        r_idle();

        // Calibration lost while a beat is presented.
        drain_to(3);
        arready = 0;
        req_valid = '1;
        for (int i = 0; i < 20 && !m_busy; i++) step();
        chk("cal_drop_busy", 64'(m_busy), 64'd1);
        init_calib_complete = 0;
        m_cal_ok = 0;
        repeat (5) step();
        arready = 1;
        step();
        arready = 0;
        keep = m_out;
        for (int i = 0; i < 30; i++) begin
            req_valid = NUM_REQ'($urandom_range(0, 15));
            step();
        end
        chk("cal_drop_keep", 64'(outstanding), 64'(keep));
        chk("cal_drop_ctrl", 64'(ctrl_ready), 64'd0);
        r_beat();
        step();
        r_idle();
        step();
        chk("cal_drop_dec", 64'(outstanding), 64'(keep - 1));
        req_valid = '0;
        init_calib_complete = 1;
        repeat (25) step();
        m_cal_ok = 1;
        chk("recal_ctrl", 64'(ctrl_ready), 64'd1);

        // Underflow, then issue and completion in the same cycle.
        drain_to(0);
        r_beat();
        step();
        r_idle();
        step();
        chk("underflow_err", 64'(err_underflow), 64'd1);
        chk("underflow_cnt", 64'(outstanding), 64'd0);
        req_valid = 4'b0001; arready = 0;
        step();
        req_valid = '0; arready = 1;
        step();
        req_valid = 4'b0001; arready = 0;
        step();
        req_valid = '0;
        step();
        arready = 1;
        r_beat();
        step();
        arready = 0;
        r_idle();
        step();
        chk("same_cycle_cnt", 64'(outstanding), 64'd1);
        chk("err_sticky", 64'(err_underflow), 64'd1);

        // Reset with a beat presented and bursts in flight.
        req_valid = 4'b0001;
        step();
        req_valid = '1;
        reset = 0;
        @(posedge clk);
        #1;
        chk("mid_rst_arvalid", 64'(arvalid), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
        chk("mid_rst_err", 64'(err_underflow), 64'd0);
        chk("mid_rst_ctrl", 64'(ctrl_ready), 64'd0);
        chk("mid_rst_arid", 64'(arid), 64'd0);
        reset = 1;
        model_reset();
        init_calib_complete = 0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
